ddr_axi_wr_master: RTL

- Downstream of the frame write buffer.
- Accepts line-burst requests on the ddr_wreq/ddr_waddr/ddr_wr_len/ddr_wdata_req handshake and turns them into AXI4 write bursts (AW, W, B) toward the DDR controller.
- Splits each request at MAX_BURST beats and at 4 KB boundaries.
- Reports completion via ddr_wdone; flags errors sticky.

---
 rtl/ddr_axi_wr_master_pkg.sv | 20 ++
 rtl/ddr_axi_wr_master_axi_burst_calc.sv | 27 ++
 rtl/ddr_axi_wr_master.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ddr_axi_wr_master_pkg.sv
// Shared types and AXI constants for the DDR AXI write master.
// Beat geometry defaults to 256-bit beats (32 bytes).
package ddr_axi_wr_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  localparam int         BEAT_BYTES     = 32;
  localparam int         BOUNDARY_4K    = 4096;
  localparam logic [2:0] AXI_SIZE_256   = 3'b101;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ddr_axi_wr_master_axi_burst_calc.sv
// Combinational burst sizing: min(remaining beats, MAX_BURST, beats left before 4 KB).
// Zero latency, no handshake.
module axi_burst_calc
  import ddr_axi_wr_master_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int MAX_BURST = 16,
  parameter int BEAT_B    = BEAT_BYTES
) (
  input  logic [LEN_WIDTH-1:0] i_rem,
  input  logic [11:0]          i_addr_lo,
  output logic [8:0]           o_beats
);

  logic [12:0] w_room;
  logic [12:0] w_sel;

  assign w_room = 13'((13'(BOUNDARY_4K) - {1'b0, i_addr_lo}) / 13'(BEAT_B));

  always_comb begin
    w_sel = 13'(MAX_BURST);
    if (w_room < w_sel) w_sel = w_room;
    if (32'(i_rem) < 32'(w_sel)) w_sel = 13'(i_rem);
    o_beats = 9'(w_sel);
  end

endmodule

// File: rtl/ddr_axi_wr_master.sv
// Line-burst request to AXI4 write bursts (split at MAX_BURST and 4 KB), one burst in flight.
// wreq->wrdy 1 cycle, awvalid 2 cycles at earliest; W stalls follow axi_wready, pops only on accepted beats.
module ddr_axi_wr_master
  import ddr_axi_wr_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 27,
  parameter int DQ_WIDTH       = BEAT_BYTES,
  parameter int LEN_WIDTH      = 16,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST      = 16
) (
  input  logic                      ddr_clk,
  input  logic                      ddr_rstn,
  input  logic                      ddr_wreq,
  input  logic [ADDR_WIDTH-1:0]     ddr_waddr,
  input  logic [LEN_WIDTH-1:0]      ddr_wr_len,
  output logic                      ddr_wrdy,
  input  logic [8*DQ_WIDTH-1:0]     ddr_wdata,
  output logic                      ddr_wdata_req,
  output logic                      ddr_wdone,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]                axi_awlen,
  output logic [2:0]                axi_awsize,
  output logic [1:0]                axi_awburst,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [8*DQ_WIDTH-1:0]     axi_wdata,
  output logic [DQ_WIDTH-1:0]       axi_wstrb,
  output logic                      axi_wlast,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  output logic                      wr_err,
  output logic                      align_err,
  output logic                      busy
);

  localparam int BEAT_B = DQ_WIDTH;

  state_t                    r_state, w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_byte_addr;
  logic [LEN_WIDTH-1:0]      r_rem;
  logic [8:0]                r_beats, r_cnt, w_beats;
  logic [7:0]                r_awlen;
  logic                      r_wrdy, r_wr_err, r_align_err, r_idle_hold;
  logic                      w_accept, w_beat_ok, w_last;
  logic [ADDR_WIDTH-1:0]     w_word_addr;

  assign w_word_addr = {ddr_waddr[ADDR_WIDTH-1:3], 3'b000};
  // r_idle_hold gives upstream one cycle after DONE to present the next address.
  assign w_accept    = (r_state == S_IDLE) && !r_idle_hold && ddr_wreq;
  assign w_beat_ok   = (r_state == S_W) && axi_wready;
  assign w_last      = (r_cnt == r_beats - 9'd1);

  axi_burst_calc #(
    .LEN_WIDTH (LEN_WIDTH),
    .MAX_BURST (MAX_BURST),
    .BEAT_B    (BEAT_B)
  ) u_calc (
    .i_rem     (r_rem),
    .i_addr_lo (r_byte_addr[11:0]),
    .o_beats   (w_beats)
  );

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    axi_awvalid   = 1'b0;
    axi_wvalid    = 1'b0;
    axi_wlast     = 1'b0;
    axi_bready    = 1'b0;
    ddr_wdata_req = 1'b0;
    ddr_wdone     = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_CALC;
      S_CALC: w_state_nxt = (r_rem == '0) ? S_DONE : S_AW;
      S_AW: begin
        axi_awvalid = 1'b1;
        if (axi_awready) w_state_nxt = S_W;
      end
      S_W: begin
        axi_wvalid    = 1'b1;
        axi_wlast     = w_last;
        ddr_wdata_req = axi_wready;
        if (axi_wready && w_last) w_state_nxt = S_B;
      end
      S_B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) w_state_nxt = S_CALC;
      end
      S_DONE: begin
        ddr_wdone   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      r_byte_addr <= '0;
      r_rem       <= '0;
      r_beats     <= '0;
      r_cnt       <= '0;
      r_awlen     <= '0;
      r_wrdy      <= 1'b0;
      r_wr_err    <= 1'b0;
      r_align_err <= 1'b0;
      r_idle_hold <= 1'b0;
    end else begin
      r_wrdy      <= w_accept;
      r_idle_hold <= (r_state == S_DONE);
      if (w_accept) begin
        r_byte_addr <= AXI_ADDR_WIDTH'(w_word_addr) * AXI_ADDR_WIDTH'(DQ_WIDTH / 8);
        r_rem       <= ddr_wr_len;
        if (ddr_waddr[2:0] != 3'b000) r_align_err <= 1'b1;
      end
      if ((r_state == S_CALC) && (r_rem != '0)) begin
        r_beats <= w_beats;
        r_awlen <= 8'(w_beats - 9'd1);
        r_cnt   <= '0;
      end
      if (w_beat_ok) r_cnt <= r_cnt + 9'd1;
      if ((r_state == S_B) && axi_bvalid) begin
        if (axi_bresp != AXI_RESP_OKAY) r_wr_err <= 1'b1;
        r_rem       <= r_rem - LEN_WIDTH'(r_beats);
        r_byte_addr <= r_byte_addr + AXI_ADDR_WIDTH'(r_beats) * AXI_ADDR_WIDTH'(BEAT_B);
      end
    end
  end

  assign ddr_wrdy    = r_wrdy;
  assign axi_awaddr  = r_byte_addr;
  assign axi_awlen   = r_awlen;
  assign axi_awsize  = AXI_SIZE_256;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wdata   = ddr_wdata;
  assign axi_wstrb   = '1;
  assign wr_err      = r_wr_err;
  assign align_err   = r_align_err;
  assign busy        = (r_state != S_IDLE);

endmodule
